// File: rtl/spi_master_cfg.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_cfg
// Description : Single-frame SPI master with per-transfer mode (CPOL/CPHA),
//               chip-select index and SCK divider. A request is taken when
//               start_i && ready_o. The frame then runs through
//               SETUP -> XFER -> HOLD -> DONE and back to IDLE.
//               SCK is made by a counter in the clk_i domain and is never
//               used as a clock.
// Ports       : clk_i      - single clock
//               reset_i    - asynchronous active-high reset
//               start_i    - transfer request
//               ready_o    - high only in IDLE
//               tx_data_i  - frame to send, MSB first
//               cs_sel_i   - target slave index (out-of-range: no select)
//               cpol_i     - SPI clock polarity
//               cpha_i     - SPI clock phase
//               clk_div_i  - SCK half-period minus one, in clk_i cycles
//               miso_i     - serial data from the slave
//               mosi_o     - serial data to the slave (registered)
//               sck_o      - SPI clock (registered)
//               cs_n_o     - active-low chip selects (registered)
//               rx_data_o  - last received frame, held until the next DONE
//               done_o     - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_cfg #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  output logic                      ready_o,
  input  logic [DATA_W-1:0]         tx_data_i,
  input  logic [$clog2(NUM_CS)-1:0] cs_sel_i,
  input  logic                      cpol_i,
  input  logic                      cpha_i,
  input  logic [DIV_W-1:0]          clk_div_i,
  input  logic                      miso_i,
  output logic                      mosi_o,
  output logic                      sck_o,
  output logic [NUM_CS-1:0]         cs_n_o,
  output logic [DATA_W-1:0]         rx_data_o,
  output logic                      done_o
);

  localparam int c_CS_W   = $clog2(NUM_CS);
  localparam int c_EDGE_W = $clog2(2*DATA_W+1);
  localparam logic [c_EDGE_W-1:0] c_LAST_EDGE = c_EDGE_W'(2*DATA_W);
  localparam logic [c_EDGE_W-1:0] c_FIRST_EDGE = c_EDGE_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DIV_W-1:0]    r_div;
  logic [DIV_W-1:0]    r_cnt;
  logic [c_EDGE_W-1:0] r_edge;
  logic                r_cpha;
  logic                r_sck;
  logic [DATA_W-1:0]   r_tx_shift;
  logic [DATA_W-1:0]   r_rx_shift;
  logic [DATA_W-1:0]   r_rx_data;
  logic [NUM_CS-1:0]   r_cs_n;
  logic                r_done;

  logic                w_half_end;
  logic [c_EDGE_W-1:0] w_edge_num;
  logic                w_last_edge;
  logic                w_sample;
  logic                w_shift;
  logic [NUM_CS-1:0]   w_cs_dec;

  // An index at or above NUM_CS matches no bit, so every select stays high.
  for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
    assign w_cs_dec[gi] = (cs_sel_i != c_CS_W'(gi));
  end

  assign w_half_end  = (r_cnt == r_div);
  assign w_edge_num  = r_edge + 1'b1;
  assign w_last_edge = (w_edge_num == c_LAST_EDGE);

  // Edge numbering starts at 1. CPHA=0 samples on odd edges and CPHA=1 on
  // even edges. The other edges shift, except the edge that would shift past
  // the frame (last edge for CPHA=0) or shift before the MSB was used
  // (edge 1 for CPHA=1).
  assign w_sample = w_edge_num[0] ^ r_cpha;
  assign w_shift  = !w_sample &&
                    !(!r_cpha && w_last_edge) &&
                    !(r_cpha && (w_edge_num == c_FIRST_EDGE));

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = S_SETUP;
      S_SETUP: if (w_half_end) w_state_nxt = S_XFER;
      S_XFER:  if (w_half_end && w_last_edge) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_half_end) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: timing counters, shift registers and registered outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_div      <= '0;
      r_cnt      <= '0;
      r_edge     <= '0;
      r_cpha     <= 1'b0;
      r_sck      <= 1'b0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_cs_n     <= '1;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_edge <= '0;
          if (start_i) begin
            // Every per-transfer setting is captured here, so input
            // changes during the frame have no effect.
            r_tx_shift <= tx_data_i;
            r_rx_shift <= '0;
            r_cpha     <= cpha_i;
            r_div      <= clk_div_i;
            r_sck      <= cpol_i;
            r_cs_n     <= w_cs_dec;
          end
        end
        S_SETUP, S_XFER, S_HOLD: begin
          r_cnt <= w_half_end ? '0 : r_cnt + 1'b1;
          if ((r_state == S_XFER) && w_half_end) begin
            // After 2*DATA_W toggles SCK is back at CPOL for HOLD.
            r_sck  <= ~r_sck;
            r_edge <= w_edge_num;
            if (w_sample) r_rx_shift <= {r_rx_shift[DATA_W-2:0], miso_i};
            if (w_shift)  r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
          end
          if ((r_state == S_HOLD) && w_half_end) begin
            r_rx_data  <= r_rx_shift;
            r_done     <= 1'b1;
            r_cs_n     <= '1;
            r_tx_shift <= '0;   // MOSI idles low from DONE onward
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  // MOSI is the MSB of the transmit shift register. This register is
  // cleared outside a frame, so MOSI is 0 in IDLE and DONE.
  assign mosi_o    = r_tx_shift[DATA_W-1];
  assign sck_o     = r_sck;
  assign cs_n_o    = r_cs_n;
  assign rx_data_o = r_rx_data;
  assign done_o    = r_done;
  assign ready_o   = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_master_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_cfg
// Description : Self-checking bench for spi_master_cfg. A second instance
//               with NUM_CS=3 shares all inputs so that an out-of-range
//               select can be observed on it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_cfg;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic [7:0] tx_data_i = 8'h00;
  logic [1:0] cs_sel_i = 2'd0;
  logic       cpol_i = 1'b0;
  logic       cpha_i = 1'b0;
  logic [7:0] clk_div_i = 8'd0;
  logic       miso_i;

  logic       ready_o, mosi_o, sck_o, done_o;
  logic [3:0] cs_n_o;
  logic [7:0] rx_data_o;
  logic       ready3, mosi3, sck3, done3;
  logic [2:0] cs_n3;
  logic [7:0] rx3;

  // Slave model
  logic       loop_en = 1'b1;
  logic       slave_bit = 1'b0;
  logic [7:0] slave_pat = 8'h00;
  logic       sl_cpha = 1'b0;
  int         sl_idx = 0;
  logic       prev_sck = 1'b0;
  logic [7:0] mos_word = 8'h00;
  int         edges = 0;
  int         first_e = 0;
  int         last_e = 0;

  logic [3:0] cur_cs4 = 4'hF;
  logic [2:0] cur_cs3 = 3'h7;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int cs_err = 0;
  int done_cnt = 0;
  int done3_cnt = 0;
  int acc_cnt = 0;
  int last_acc = 0;
  int last_done = 0;

  typedef struct {
    logic [7:0] rx;
    int         cyc;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] div;
    logic [7:0] tx;
    logic [1:0] cs;
    logic       loop;
    logic [7:0] pat;
    logic [7:0] exp_rx;
    int         exp_lat;
    logic [3:0] exp_cs;
    logic [2:0] exp_cs3;
  } vec_t;
  vec_t tbl[5];

  assign miso_i = loop_en ? mosi_o : slave_bit;

  spi_master_cfg dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .ready_o(ready_o),
    .tx_data_i(tx_data_i), .cs_sel_i(cs_sel_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
    .clk_div_i(clk_div_i), .miso_i(miso_i), .mosi_o(mosi_o), .sck_o(sck_o),
    .cs_n_o(cs_n_o), .rx_data_o(rx_data_o), .done_o(done_o)
  );

  spi_master_cfg #(.NUM_CS(3)) dut3 (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .ready_o(ready3),
    .tx_data_i(tx_data_i), .cs_sel_i(cs_sel_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
    .clk_div_i(clk_div_i), .miso_i(miso_i), .mosi_o(mosi3), .sck_o(sck3),
    .cs_n_o(cs_n3), .rx_data_o(rx3), .done_o(done3)
  );

  initial forever #5 clk_i = ~clk_i;
  initial forever begin @(posedge clk_i); cyc++; end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: SCK edges, slave model, chip selects, scoreboard and acceptances.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!reset_i) begin
        if (!ready_o) begin
          if (sck_o !== prev_sck) begin
            edges++;
            prev_sck = sck_o;
            if (edges == 1) first_e = cyc;
            last_e = cyc;
            if ((edges % 2 == 1) == (sl_cpha == 1'b0)) begin
              mos_word = {mos_word[6:0], mosi_o};
            end else if (sl_idx < 8) begin
              slave_bit = slave_pat[7-sl_idx];
              sl_idx++;
            end
          end
          if (done_o) begin
            if (cs_n_o !== 4'hF || cs_n3 !== 3'h7) cs_err++;
          end else if (cs_n_o !== cur_cs4 || cs_n3 !== cur_cs3) begin
            cs_err++;
          end
        end else if (cs_n_o !== 4'hF || cs_n3 !== 3'h7) begin
          cs_err++;
        end
        if (done3) done3_cnt++;
        if (done_o) begin
          done_cnt++;
          last_done = cyc;
          if (sbq.size() == 0) begin
            chk("sb_done_without_request", sbq.size(), 1);
          end else begin
            sb_t e;
            e = sbq.pop_front();
            chk("sb_rx_data", rx_data_o, e.rx);
            chk("sb_done_cycle", cyc, e.cyc);
          end
        end
        if (start_i && ready_o) begin
          sb_t n;
          acc_cnt++;
          last_acc = cyc;
          n.rx  = loop_en ? tx_data_i : slave_pat;
          n.cyc = cyc + 1 + 18 * (int'(clk_div_i) + 1);
          sbq.push_back(n);
          edges = 0;
          mos_word = 8'h00;
          prev_sck = cpol_i;
          sl_cpha = cpha_i;
          if (!cpha_i) begin
            slave_bit = slave_pat[7];
            sl_idx = 1;
          end else begin
            slave_bit = 1'b0;
            sl_idx = 0;
          end
        end
      end
    end
  end

  task automatic wait_done();
    int n0;
    int k;
    n0 = done_cnt;
    k = 0;
    while (done_cnt == n0 && k < 2000) begin
      @(posedge clk_i);
      k++;
    end
    chk("done_seen", done_cnt - n0, 1);
  endtask

  task automatic run_xfer(input vec_t e);
    int cs0;
    int d30;
    @(posedge clk_i); #1;
    cpol_i = e.cpol; cpha_i = e.cpha; clk_div_i = e.div; tx_data_i = e.tx;
    cs_sel_i = e.cs; loop_en = e.loop; slave_pat = e.pat;
    cur_cs4 = e.exp_cs; cur_cs3 = e.exp_cs3;
    cs0 = cs_err;
    d30 = done3_cnt;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("busy_after_accept", ready_o, 1'b0);
    // Scramble every input; the running frame must not notice.
    tx_data_i = ~e.tx; cpol_i = ~e.cpol; cpha_i = ~e.cpha;
    clk_div_i = 8'd7; cs_sel_i = ~e.cs;
    wait_done();
    #1;
    chk("ready_after_done", ready_o, 1'b1);
    chk("latency", last_done - last_acc, e.exp_lat);
    chk("rx_data", rx_data_o, e.exp_rx);
    chk("sck_edges", edges, 16);
    chk("sck_span", last_e - first_e, 15 * (int'(e.div) + 1));
    chk("mosi_msb_first", mos_word, e.tx);
    chk("sck_idle_cpol", sck_o, e.cpol);
    chk("mosi_idle", mosi_o, 1'b0);
    chk("cs_n_pattern_errs", cs_err - cs0, 0);
    chk("dut3_done", done3_cnt - d30, 1);
    @(posedge clk_i); #1;
    chk("rx_hold", rx_data_o, e.exp_rx);
    chk("done_one_cycle", done_o, 1'b0);
  endtask

  initial begin
    int a0;
    int d;
    int n0;
    int k;
    //           cpol  cpha  div    tx     cs    loop  pat    exp_rx lat  cs4      cs3
    tbl[0] = '{1'b0, 1'b0, 8'd0, 8'hA5, 2'd0, 1'b1, 8'h00, 8'hA5, 19, 4'b1110, 3'b110};
    tbl[1] = '{1'b1, 1'b1, 8'd3, 8'h3C, 2'd0, 1'b0, 8'hFF, 8'hFF, 73, 4'b1110, 3'b110};
    tbl[2] = '{1'b0, 1'b1, 8'd1, 8'h69, 2'd1, 1'b0, 8'h96, 8'h96, 37, 4'b1101, 3'b101};
    tbl[3] = '{1'b1, 1'b0, 8'd2, 8'h81, 2'd2, 1'b0, 8'h96, 8'h96, 55, 4'b1011, 3'b011};
    tbl[4] = '{1'b0, 1'b0, 8'd0, 8'h5A, 2'd3, 1'b1, 8'h00, 8'h5A, 19, 4'b0111, 3'b111};

    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_ready", ready_o, 1'b1);
    chk("reset_sck", sck_o, 1'b0);
    chk("reset_cs_n", cs_n_o, 4'hF);
    chk("reset_mosi", mosi_o, 1'b0);
    chk("reset_rx", rx_data_o, 8'h00);
    chk("reset_done", done_o, 1'b0);
    reset_i = 1'b0;
    @(posedge clk_i); #1;

    for (int i = 0; i < 5; i++) run_xfer(tbl[i]);

    // start_i held high with tx changed mid-frame: one frame, then re-accept.
    @(posedge clk_i); #1;
    cpol_i = 1'b0; cpha_i = 1'b0; clk_div_i = 8'd0; tx_data_i = 8'h5A; cs_sel_i = 2'd0;
    loop_en = 1'b1; cur_cs4 = 4'b1110; cur_cs3 = 3'b110;
    a0 = acc_cnt;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    tx_data_i = 8'hFF;
    wait_done();
    #1;
    chk("held_single_accept", acc_cnt - a0, 1);
    chk("held_rx_original", rx_data_o, 8'h5A);
    d = last_done;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("held_reaccept_count", acc_cnt - a0, 2);
    chk("held_reaccept_cycle", last_acc - d, 1);
    wait_done();
    #1;
    chk("held_second_rx", rx_data_o, 8'hFF);

    // Reset near edge 5 of a frame.
    @(posedge clk_i); #1;
    cpol_i = 1'b0; cpha_i = 1'b0; clk_div_i = 8'd1; tx_data_i = 8'hC3; cs_sel_i = 2'd1;
    loop_en = 1'b1; cur_cs4 = 4'b1101; cur_cs3 = 3'b101;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    k = 0;
    while (edges < 5 && k < 500) begin
      @(posedge clk_i); #1;
      k++;
    end
    chk("abort_reached_edge5", edges, 5);
    reset_i = 1'b1;
    #1;
    sbq.delete();
    n0 = done_cnt;
    chk("abort_ready", ready_o, 1'b1);
    chk("abort_sck", sck_o, 1'b0);
    chk("abort_cs_n", cs_n_o, 4'hF);
    chk("abort_mosi", mosi_o, 1'b0);
    chk("abort_rx", rx_data_o, 8'h00);
    chk("abort_done", done_o, 1'b0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    repeat (60) @(posedge clk_i);
    #1;
    chk("abort_no_done", done_cnt - n0, 0);
    chk("abort_rx_stays", rx_data_o, 8'h00);

    // Normal operation resumes after reset.
    run_xfer(tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
